// File: rtl/icache_responder_pkg.sv
// Shared types and default geometry for the instruction cache responder.
// The FSM state encodings live here.
package icache_responder_pkg;

    localparam int ICACHE_ADDR_W   = 32;
    localparam int ICACHE_DATA_W   = 32;
    localparam int ICACHE_INDEX_W  = 6;
    localparam int ICACHE_OFFSET_W = 2;

    typedef enum logic [1:0] {
        ICACHE_IDLE   = 2'd0,
        ICACHE_REFILL = 2'd1,
        ICACHE_RESP   = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Reads are combinational by index; word, tag and valid writes are synchronous.
module icache_line_store
    import icache_responder_pkg::*;
#(
    parameter int DATA_W   = ICACHE_DATA_W,
    parameter int INDEX_W  = ICACHE_INDEX_W,
    parameter int OFFSET_W = ICACHE_OFFSET_W,
    parameter int TAG_W    = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_idx,
    input  logic [OFFSET_W-1:0] rd_off,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_idx,
    input  logic [OFFSET_W-1:0] wr_off,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                tag_wr_en,
    input  logic [TAG_W-1:0]    tag_wr,
    input  logic                valid_set,
    input  logic                flush_all
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = LINES << OFFSET_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [WORDS];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[{rd_idx, rd_off}];

    // A flush outranks a same-cycle tag write so a flushed refill stays invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (tag_wr_en) begin
            valid[wr_idx] <= valid_set;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tag_mem[wr_idx] <= tag_wr;
        end
        if (wr_en) begin
            data_mem[{wr_idx, wr_off}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache, responder side of the fetcher handshake.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt counters and ports.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int ADDR_W   = ICACHE_ADDR_W,
    parameter int DATA_W   = ICACHE_DATA_W,
    parameter int INDEX_W  = ICACHE_INDEX_W,
    parameter int OFFSET_W = ICACHE_OFFSET_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rw_flag,
    input  logic [ADDR_W-1:0] addr,
    input  logic              flush,
    output logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;

    icache_state_t state, state_nxt;

    logic [TAG_W-1:0]    in_tag, lat_tag, rd_tag;
    logic [INDEX_W-1:0]  in_idx, lat_idx;
    logic [OFFSET_W-1:0] in_off, lat_off, cnt;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                accept, hit, hit_done, flush_pend;
    logic                refill_wr, last_word, flush_all;
    logic                unused_ok;

    assign in_tag = addr[ADDR_W-1 -: TAG_W];
    assign in_idx = addr[2+OFFSET_W +: INDEX_W];
    assign in_off = addr[2 +: OFFSET_W];
    assign unused_ok = ^{addr[1:0], rw_flag[1]};

    assign accept    = (state == ICACHE_IDLE) && rw_flag[0] && !flush;
    assign hit       = rd_valid && (rd_tag == in_tag);
    assign refill_wr = (state == ICACHE_REFILL) && mem_valid;
    assign last_word = refill_wr && (&cnt);
    // A flush seen during a refill is applied once the response is out.
    assign flush_all = ((state != ICACHE_REFILL) && flush) ||
                       ((state == ICACHE_RESP) && flush_pend);

    icache_line_store #(
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .OFFSET_W(OFFSET_W),
        .TAG_W   (TAG_W)
    ) u_line_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (in_idx),
        .rd_off   (in_off),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (refill_wr),
        .wr_idx   (lat_idx),
        .wr_off   (cnt),
        .wr_data  (mem_rdata),
        .tag_wr_en(last_word),
        .tag_wr   (lat_tag),
        .valid_set(!(flush_pend || flush)),
        .flush_all(flush_all)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ICACHE_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ICACHE_IDLE:   if (accept && !hit) state_nxt = ICACHE_REFILL;
            ICACHE_REFILL: if (last_word)      state_nxt = ICACHE_RESP;
            ICACHE_RESP:                       state_nxt = ICACHE_IDLE;
            default:                           state_nxt = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ICACHE_REFILL);
        mem_req  = (state == ICACHE_REFILL);
        done     = hit_done || (state == ICACHE_RESP);
        mem_addr = '0;
        if (state == ICACHE_REFILL) begin
            mem_addr = {lat_tag, lat_idx, cnt, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_done   <= 1'b0;
            flush_pend <= 1'b0;
            cnt        <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_off    <= '0;
            read_data  <= '0;
        end else begin
            hit_done <= accept && hit;
            if (accept) begin
                lat_tag <= in_tag;
                lat_idx <= in_idx;
                lat_off <= in_off;
                cnt     <= '0;
                if (hit) begin
                    read_data <= rd_data;
                end
            end
            if (refill_wr) begin
                cnt <= cnt + 1'b1;
                if (cnt == lat_off) begin
                    read_data <= mem_rdata;
                end
            end
            if (state == ICACHE_RESP) begin
                flush_pend <= 1'b0;
            end else if ((state == ICACHE_REFILL) && flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (accept) begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end else begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Randomized bench for icache_responder against a line-level cache model.
// Counter checks are active when ICACHE_STATS_EN is defined.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rw_flag;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] read_data;
    logic        busy, done, mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic [31:0] hit_cnt, miss_cnt;

    int vectors = 0;
    int errors  = 0;

    // Reference model: per-line valid/tag, plus access counters.
    bit          mvalid [64];
    logic [21:0] mtag   [64];
    int          n_hit, n_miss;

    logic [31:0] seen_q [$];
    bit          mem_en = 1'b1;
    bit          stray  = 1'b0;

    always #5 clk = ~clk;

    icache_responder dut (
        .clk      (clk),
        .rst      (rst),
        .rw_flag  (rw_flag),
        .addr     (addr),
        .flush    (flush),
        .read_data(read_data),
        .busy     (busy),
        .done     (done),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

`ifndef ICACHE_STATS_EN
    assign hit_cnt  = 32'd0;
    assign miss_cnt = 32'd0;
`endif

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    // Memory side: answers each word request after 0..2 idle cycles.
    initial begin
        int dly;
        dly = 0;
        mem_valid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (mem_en && mem_req) begin
                if (dly == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = memfn(mem_addr);
                    seen_q.push_back(mem_addr);
                    dly = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end else if (stray) begin
                mem_valid = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    endtask

    task automatic check_stats(input string name);
`ifdef ICACHE_STATS_EN
        vectors++;
        if (hit_cnt !== n_hit || miss_cnt !== n_miss) begin
            errors++;
            $display("FAIL %s: hit/miss got %0d/%0d want %0d/%0d", name, hit_cnt, miss_cnt, n_hit, n_miss);
        end
`else
        $display("stats %s skipped (%0d/%0d)", name, n_hit, n_miss);
`endif
    endtask

    task automatic do_read(input logic [31:0] a, input bit flush_mid, input string name);
        logic [31:0] base, aw;
        logic [5:0]  idx;
        logic [21:0] tg;
        bit          exp_hit, flushed, got;
        aw   = {a[31:2], 2'b00};
        base = {a[31:4], 4'h0};
        idx  = a[9:4];
        tg   = a[31:10];
        exp_hit = mvalid[idx] && (mtag[idx] == tg);
        seen_q.delete();
        rw_flag = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
        addr    = aw | 32'($urandom_range(0, 3));
        @(posedge clk); #1;
        rw_flag = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
        addr    = $urandom;
        if (exp_hit) begin
            n_hit++;
            vectors++;
            if ({busy, mem_req, done} !== 3'b001 || read_data !== memfn(aw)) begin
                errors++;
                $display("FAIL %s hit: busy/req/done=%b data=%h want 001 data=%h",
                         name, {busy, mem_req, done}, read_data, memfn(aw));
            end
            rw_flag = 2'b00;
            return;
        end
        n_miss++;
        vectors++;
        if ({busy, mem_req, done} !== 3'b110 || mem_addr !== base) begin
            errors++;
            $display("FAIL %s miss start: busy/req/done=%b mem_addr=%h want 110 %h",
                     name, {busy, mem_req, done}, mem_addr, base);
        end
        flushed = 1'b0;
        got = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (flush_mid && !flushed && seen_q.size() >= 1) begin
                flush = 1'b1;
                flushed = 1'b1;
            end
            @(posedge clk); #1;
            flush = 1'b0;
            if (done && busy) begin
                vectors++;
                errors++;
                $display("FAIL %s overlap: done=1 busy=1 want not both", name);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        vectors++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: done=0 want 1 within 200 cycles", name);
            return;
        end
        if (read_data !== memfn(aw)) begin
            errors++;
            $display("FAIL %s data: got %h want %h", name, read_data, memfn(aw));
        end
        vectors++;
        if (seen_q.size() != 4) begin
            errors++;
            $display("FAIL %s words: got %0d requests want 4", name, seen_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (seen_q[k] !== base + 32'(4 * k)) begin
                    errors++;
                    $display("FAIL %s mem_addr[%0d]: got %h want %h", name, k, seen_q[k], base + 32'(4 * k));
                end
            end
        end
        if (flushed) begin
            model_clear();
        end else begin
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
        end
        rw_flag = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if ({busy, mem_req, done} !== 3'b000) begin
            errors++;
            $display("FAIL %s after resp: busy/req/done=%b want 000", name, {busy, mem_req, done});
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        n_hit = 0;
        n_miss = 0;
    endtask

    task automatic test_reset();
        rw_flag = 2'b00; addr = 32'd0; flush = 1'b0;
        apply_reset();
        vectors++;
        if ({busy, done, mem_req} !== 3'b000 || read_data !== 32'd0 || mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset: busy/done/req=%b data=%h mem_addr=%h want 000 0 0",
                     {busy, done, mem_req}, read_data, mem_addr);
        end
        check_stats("reset");
    endtask

    task automatic test_directed();
        do_read(32'h100, 1'b0, "cold_0x100");
        do_read(32'h104, 1'b0, "reread_0x104");
        do_read(32'h1100, 1'b0, "conflict_0x1100");
        do_read(32'h100, 1'b0, "conflict_0x100");
        do_read(32'h200, 1'b1, "flush_mid_0x200");
        do_read(32'h200, 1'b0, "after_flush_0x200");
    endtask

    task automatic test_reset_mid_refill();
        bit reached;
        reached = 1'b0;
        seen_q.delete();
        rw_flag = 2'b01; addr = 32'h600;
        @(posedge clk); #1;
        rw_flag = 2'b00;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (seen_q.size() >= 2) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_mid timeout: words=%0d want 2", seen_q.size());
        end
        rst = 1'b1; mem_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        n_hit = 0; n_miss = 0;
        vectors++;
        if ({busy, done, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid abort: busy/done/req=%b want 000", {busy, done, mem_req});
        end
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid stray: busy/done/req=%b want 000", {busy, done, mem_req});
        end
        mem_en = 1'b1;
        do_read(32'h200, 1'b0, "post_rst_0x200");
    endtask

    task automatic test_flush_idle();
        do_read(32'h100, 1'b0, "prefill_0x100");
        flush = 1'b1; rw_flag = 2'b01; addr = 32'h100;
        @(posedge clk); #1;
        flush = 1'b0; rw_flag = 2'b00;
        model_clear();
        vectors++;
        if ({busy, done, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL flush_idle: busy/done/req=%b want 000", {busy, done, mem_req});
        end
        do_read(32'h108, 1'b0, "after_idle_flush");
    endtask

    task automatic test_no_read();
        rw_flag = 2'b10; addr = 32'h100;
        @(posedge clk); #1;
        rw_flag = 2'b00;
        vectors++;
        if ({busy, done, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL rw10: busy/done/req=%b want 000", {busy, done, mem_req});
        end
        check_stats("rw10");
    endtask

    task automatic test_back_to_back();
        do_read(32'h300, 1'b0, "prefill_0x300");
        for (int i = 0; i < 4; i++) begin
            rw_flag = 2'b01;
            addr = 32'h300 + 32'(4 * ((i + 1) % 4));
            @(posedge clk); #1;
            n_hit++;
            vectors++;
            if (done !== 1'b1 || read_data !== memfn(32'h300 + 32'(4 * ((i + 1) % 4)))) begin
                errors++;
                $display("FAIL b2b[%0d]: done=%b data=%h want 1 %h", i, done, read_data,
                         memfn(32'h300 + 32'(4 * ((i + 1) % 4))));
            end
        end
        rw_flag = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b end: done=%b want 0", done);
        end
    endtask

    task automatic test_stats();
        apply_reset();
        do_read(32'h400, 1'b0, "stats_miss1");
        do_read(32'h404, 1'b0, "stats_hit1");
        do_read(32'h40C, 1'b0, "stats_hit2");
        do_read(32'h800, 1'b0, "stats_miss2");
        check_stats("seq");
        test_no_read();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(0, 1)) << 10) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
            do_read(a, ($urandom_range(0, 7) == 0), "random");
        end
        check_stats("random");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_refill();
        test_flush_idle();
        test_no_read();
        test_back_to_back();
        test_random();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
